// File: rtl/data_cache_ctrl_if.sv
// Core and memory-side bus bundle for the L1 data cache controller.
// The slave modport is the cache's view; master is the core/memory side.
interface data_cache_ctrl_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  MemRead;
   logic                  MemWrite;
   logic [ADDR_WIDTH-1:0] Addr;
   logic [DATA_WIDTH-1:0] WriteData;
   logic [DATA_WIDTH-1:0] ReadData;
   logic                  Stall;
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  mem_ready;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport slave (
      input  MemRead, MemWrite, Addr, WriteData,
      input  mem_ready, mem_rdata,
      output ReadData, Stall,
      output mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output MemRead, MemWrite, Addr, WriteData,
      output mem_ready, mem_rdata,
      input  ReadData, Stall,
      input  mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache controller.
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.
module data_cache_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int IDX_BITS   = 5
) (
   input  logic CLK,
   input  logic RST,
   data_cache_ctrl_if.slave bus
`ifdef CACHE_STATS_EN
   ,
   output logic [15:0] hit_cnt,
   output logic [15:0] miss_cnt
`endif
);

   localparam int NUM_LINES = 2 ** IDX_BITS;
   localparam int TAG_BITS  = ADDR_WIDTH - IDX_BITS - 2;

   typedef enum logic [1:0] {
      IDLE,
      RD_MISS,
      WR_THRU,
      DONE
   } state_t;

   state_t state, state_nx;

   logic [NUM_LINES-1:0]  valid;
   logic [TAG_BITS-1:0]   tag_ram  [NUM_LINES];
   logic [DATA_WIDTH-1:0] data_ram [NUM_LINES];
   logic [DATA_WIDTH-1:0] rd_buf;

   logic [IDX_BITS-1:0] idx;
   logic [TAG_BITS-1:0] tag;
   logic [IDX_BITS-1:0] mem_idx;
   logic [TAG_BITS-1:0] mem_tag;
   logic                hit;
   logic                mem_hit;
   logic                in_mem;
   logic                unused_bits;

   assign idx     = bus.Addr[IDX_BITS+1:2];
   assign tag     = bus.Addr[ADDR_WIDTH-1:IDX_BITS+2];
   assign mem_idx = bus.mem_addr[IDX_BITS+1:2];
   assign mem_tag = bus.mem_addr[ADDR_WIDTH-1:IDX_BITS+2];
   assign hit     = valid[idx] && (tag_ram[idx] == tag);
   assign mem_hit = valid[mem_idx] && (tag_ram[mem_idx] == mem_tag);
   assign in_mem  = (state == RD_MISS) || (state == WR_THRU);

   assign unused_bits = ^{bus.Addr[1:0], bus.mem_addr[1:0]};

   always_comb begin
      state_nx     = state;
      bus.Stall    = 1'b0;
      bus.ReadData = '0;
      unique case (state)
         IDLE: begin
            if (bus.MemWrite) begin
               state_nx  = WR_THRU;
               bus.Stall = 1'b1;
            end else if (bus.MemRead) begin
               if (hit) begin
                  bus.ReadData = data_ram[idx];
               end else begin
                  state_nx  = RD_MISS;
                  bus.Stall = 1'b1;
               end
            end
         end
         RD_MISS, WR_THRU: begin
            bus.Stall = 1'b1;
            if (bus.mem_ready) state_nx = DONE;
         end
         DONE: begin
            state_nx = IDLE;
            if (bus.MemRead && !bus.mem_we) bus.ReadData = rd_buf;
         end
         default: state_nx = IDLE;
      endcase
      // Reset dominates so the core is never frozen while it is held in reset
      if (RST) begin
         bus.Stall    = 1'b0;
         bus.ReadData = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state         <= IDLE;
         valid         <= '0;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         rd_buf        <= '0;
      end else begin
         state <= state_nx;
         // Request fields are captured once on entry and held until ready
         if (state == IDLE && state_nx != IDLE) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.MemWrite;
            bus.mem_addr  <= {bus.Addr[ADDR_WIDTH-1:2], 2'b00};
            bus.mem_wdata <= bus.WriteData;
         end
         if (in_mem && bus.mem_ready) bus.mem_req <= 1'b0;
         if (state == RD_MISS && bus.mem_ready) begin
            valid[mem_idx] <= 1'b1;
            rd_buf         <= bus.mem_rdata;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST && bus.mem_ready) begin
         if (state == RD_MISS) begin
            data_ram[mem_idx] <= bus.mem_rdata;
            tag_ram[mem_idx]  <= mem_tag;
         end else if (state == WR_THRU && mem_hit) begin
            data_ram[mem_idx] <= bus.mem_wdata;
         end
      end
   end

`ifdef CACHE_STATS_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (state == IDLE && bus.MemRead && !bus.MemWrite) begin
         if (hit) begin
            if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
         end else begin
            if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Directed self-checking bench for data_cache_ctrl.
// Stats checks are compiled in when CACHE_STATS_EN is defined.
module tb_data_cache_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   data_cache_ctrl_if bus ();

`ifdef CACHE_STATS_EN
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;
`endif

   data_cache_ctrl dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
`ifdef CACHE_STATS_EN
      ,
      .hit_cnt  (hit_cnt),
      .miss_cnt (miss_cnt)
`endif
   );

   int compared   = 0;
   int mismatched = 0;

   int          stalls;
   logic [31:0] rdv;
   logic [31:0] maddr;
   logic [31:0] mwdata;
   logic        mwe;
   logic        mreq;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One core access; memory answers after lat cycles of mem_req.
   task automatic access(input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int lat, input logic [31:0] md);
      int  n    = 0;
      int  cyc  = 0;
      bit  done = 0;
      stalls = 0;
      mreq   = 1'b0;
      rdv    = 'x;
      bus.MemRead   = rd;
      bus.MemWrite  = wr;
      bus.Addr      = a;
      bus.WriteData = wd;
      while (!done) begin
         if (bus.mem_req) begin
            n++;
            if (!mreq) begin
               maddr  = bus.mem_addr;
               mwe    = bus.mem_we;
               mwdata = bus.mem_wdata;
            end
            mreq          = 1'b1;
            bus.mem_ready = (n >= lat);
            bus.mem_rdata = md;
         end else begin
            bus.mem_ready = 1'b0;
         end
         @(negedge clk);
         if (bus.Stall) stalls++;
         else begin
            rdv  = bus.ReadData;
            done = 1;
         end
         cyc++;
         if (!done && cyc > 40) begin
            compared++;
            mismatched++;
            $error("FAIL timeout: observed %0d stall cycles required < 40", cyc);
            done = 1;
         end
         @(posedge clk);
         #1;
      end
      bus.MemRead   = 1'b0;
      bus.MemWrite  = 1'b0;
      bus.mem_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst           = 1'b1;
      bus.MemRead   = 1'b1;
      bus.MemWrite  = 1'b0;
      bus.Addr      = 32'h40;
      bus.WriteData = '0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_stall", {31'd0, bus.Stall}, 32'd0);
      chk("rst_rdata", bus.ReadData, 32'd0);
      chk("rst_req", {31'd0, bus.mem_req}, 32'd0);
      chk("rst_we", {31'd0, bus.mem_we}, 32'd0);
      chk("rst_maddr", bus.mem_addr, 32'd0);
      chk("rst_wdata", bus.mem_wdata, 32'd0);
`ifdef CACHE_STATS_EN
      chk("rst_hits", {16'd0, hit_cnt}, 32'd0);
      chk("rst_miss", {16'd0, miss_cnt}, 32'd0);
`endif
      @(posedge clk);
      #1;
      rst         = 1'b0;
      bus.MemRead = 1'b0;
      @(posedge clk);
      #1;

      // load miss with two memory cycles
      access(1, 0, 32'h40, 0, 2, 32'hDEADBEEF);
      chk("t1_stalls", stalls, 3);
      chk("t1_maddr", maddr, 32'h40);
      chk("t1_we", {31'd0, mwe}, 32'd0);
      chk("t1_rdata", rdv, 32'hDEADBEEF);

      access(1, 0, 32'h40, 0, 2, 32'h0);
      chk("t2_stalls", stalls, 0);
      chk("t2_rdata", rdv, 32'hDEADBEEF);
      chk("t2_req", {31'd0, mreq}, 32'd0);

      access(0, 1, 32'h40, 32'h12345678, 2, 32'h0);
      chk("t3_st_stalls", stalls, 3);
      chk("t3_st_req", {31'd0, mreq}, 32'd1);
      chk("t3_st_we", {31'd0, mwe}, 32'd1);
      chk("t3_st_wdata", mwdata, 32'h12345678);
      chk("t3_st_rdata", rdv, 32'd0);
      access(1, 0, 32'h40, 0, 1, 32'h0);
      chk("t3_ld_stalls", stalls, 0);
      chk("t3_ld_rdata", rdv, 32'h12345678);
      access(0, 1, 32'h80, 32'hCAFEF00D, 1, 32'h0);
      chk("t3_st80_stalls", stalls, 2);
      chk("t3_st80_maddr", maddr, 32'h80);
      chk("t3_st80_we", {31'd0, mwe}, 32'd1);
      access(1, 0, 32'h80, 0, 1, 32'h0BADF00D);
      chk("t3_ld80_stalls", stalls, 2);
      chk("t3_ld80_rdata", rdv, 32'h0BADF00D);

      // same index, different tag: mutual eviction
      access(1, 0, 32'h40, 0, 1, 32'h0);
      chk("t4_hit_stalls", stalls, 0);
      chk("t4_hit_rdata", rdv, 32'h12345678);
      access(1, 0, 32'hC0, 0, 3, 32'hC0C0C0C0);
      chk("t4_c0_stalls", stalls, 4);
      chk("t4_c0_maddr", maddr, 32'hC0);
      chk("t4_c0_rdata", rdv, 32'hC0C0C0C0);
      access(1, 0, 32'h40, 0, 1, 32'h11112222);
      chk("t4_evict_stalls", stalls, 2);
      chk("t4_evict_rdata", rdv, 32'h11112222);
      access(1, 0, 32'h43, 0, 1, 32'h0);
      chk("t4_unalign_stalls", stalls, 0);
      chk("t4_unalign_rdata", rdv, 32'h11112222);

      // reset in the middle of a read miss
      bus.MemRead = 1'b1;
      bus.Addr    = 32'h200;
      @(posedge clk);
      #1;
      chk("t5_req_up", {31'd0, bus.mem_req}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_rst_stall", {31'd0, bus.Stall}, 32'd0);
      chk("t5_rst_rdata", bus.ReadData, 32'd0);
      @(posedge clk);
      #1;
      rst           = 1'b0;
      bus.MemRead   = 1'b0;
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h55555555;
      @(negedge clk);
      chk("t5_req_down", {31'd0, bus.mem_req}, 32'd0);
      chk("t5_stall", {31'd0, bus.Stall}, 32'd0);
      @(posedge clk);
      #1;
      bus.mem_ready = 1'b0;
      @(negedge clk);
      chk("t5_late_ready", {31'd0, bus.mem_req}, 32'd0);
      @(posedge clk);
      #1;
      access(1, 0, 32'h200, 0, 2, 32'h22220000);
      chk("t5_reload_stalls", stalls, 3);
      chk("t5_reload_rdata", rdv, 32'h22220000);
      access(1, 0, 32'h40, 0, 1, 32'h33334444);
      chk("t5_cleared_stalls", stalls, 2);

`ifdef CACHE_STATS_EN
      do_reset();
      @(negedge clk);
      chk("t6_clr_hits", {16'd0, hit_cnt}, 32'd0);
      chk("t6_clr_miss", {16'd0, miss_cnt}, 32'd0);
      @(posedge clk);
      #1;
      access(1, 0, 32'h300, 0, 1, 32'hA);
      access(1, 0, 32'h304, 0, 1, 32'hB);
      access(1, 0, 32'h300, 0, 1, 32'h0);
      access(1, 0, 32'h304, 0, 1, 32'h0);
      access(1, 0, 32'h300, 0, 1, 32'h0);
      chk("t6_hits", {16'd0, hit_cnt}, 32'd3);
      chk("t6_miss", {16'd0, miss_cnt}, 32'd2);
      access(0, 1, 32'h300, 32'h7, 1, 32'h0);
      access(0, 1, 32'h800, 32'h8, 1, 32'h0);
      chk("t6_st_hits", {16'd0, hit_cnt}, 32'd3);
      chk("t6_st_miss", {16'd0, miss_cnt}, 32'd2);
`else
      do_reset();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end
endmodule
